// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   AHB responder in front of a 32-bit wide, little-endian on-chip SRAM.
//   It decodes address phases and inserts WAIT_STATES wait cycles per
//   good beat. It performs byte/halfword/word accesses and answers illegal
//   transfers with the two-cycle ERROR response.
//
// Parameters
//   ADDR_WIDTH  : byte-address width; array depth is 2^ADDR_WIDTH bytes
//   WAIT_STATES : wait cycles inserted per non-error beat (0..7)
//
// Ports
//   HCLK        : clock, rising edge
//   HRESET      : asynchronous active-high reset
//   HSEL        : slave select from the address decoder
//   HADDR       : byte address (address phase)
//   HWRITE      : 1 = write (address phase)
//   HTRANS      : IDLE/BUSY/NONSEQ/SEQ
//   HSIZE       : transfer size
//   HBURST      : burst type, accepted but unused
//   HWDATA      : write data (data phase)
//   HREADY      : bus-level ready from the fabric mux
//   HREADYOUT   : this slave's ready
//   HRESP       : OKAY (2'b00) or ERROR (2'b01)
//   HRDATA      : read data, zero outside a read data phase
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          WORDS   = 2 ** (ADDR_WIDTH - 2);
  localparam logic [2:0]  WS      = 3'(WAIT_STATES);
  localparam logic [1:0]  RESP_OK = 2'b00;
  localparam logic [1:0]  RESP_ER = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    rdy_q, rdy_d;
  logic [1:0]              resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [31:0]             mem [WORDS];

  logic                    can_take;
  logic                    take;
  logic                    xfer_err;
  logic [3:0]              lane_en;

  // Byte lanes touched by a transfer of the given size at the given
  // low address bits (size/alignment already checked at acceptance).
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] lo);
    case (size)
      3'd0:    lane_mask = 4'b0001 << lo;
      3'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // A new address phase can only be taken when the previous data phase is
  // in its final (HREADYOUT=1) cycle or the slave is idle.
  assign can_take = (state_q == S_IDLE) || (state_q == S_DATA) ||
                    (state_q == S_ERR2);
  assign take     = can_take && HSEL && HREADY && HTRANS[1];

  assign xfer_err = (HSIZE > 3'd2) ||
                    ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                    ((HADDR >> ADDR_WIDTH) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        cnt_d = 3'd0;
        if (take) begin
          if (xfer_err) begin
            state_d = S_ERR1;
          end else if (WS == 3'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DATA;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    rdy_d  = !((state_d == S_WAIT) || (state_d == S_ERR1));
    resp_d = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ER : RESP_OK;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdy_q   <= 1'b1;
      resp_q  <= RESP_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      resp_q  <= resp_d;
    end
  end

  // Address-phase capture: data path only, no reset needed.
  always_ff @(posedge HCLK) begin
    if (take) begin
      addr_q  <= HADDR[ADDR_WIDTH-1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  // Write lands on the edge that closes the DATA cycle, so a pipelined read
  // of the same word in the next data phase already sees it.
  assign lane_en = lane_mask(size_q, addr_q[1:0]);

  always_ff @(posedge HCLK) begin
    if ((state_q == S_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = rdy_q;
  assign HRESP     = resp_q;
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ?
                     mem[addr_q[ADDR_WIDTH-1:2]] : 32'd0;

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//   Two instances: WAIT_STATES=2 (u_ws2, index 0) and WAIT_STATES=0
//   (u_ws0, index 1). A transaction-level driver overlaps each address phase
//   with the previous data phase. A byte-array memory model predicts the
//   response and read data of every data-phase cycle.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int         AW     = 10;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hsel, hwrite, hready, hready_en, hreadyout;
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [31:0] hwdata [2];
  logic [1:0]  hresp  [2];
  logic [31:0] hrdata [2];

  always #5 clk = ~clk;

  assign hready = hreadyout & hready_en;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]),
    .HBURST(hburst[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]),
    .HBURST(hburst[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  typedef struct {
    bit          xfer;
    bit          err;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  int          checks   = 0;
  int          failures = 0;
  int          ws_of [2];
  logic [7:0]  rmem [2][1024];
  txn_t        pend [2];
  logic [31:0] last_rd [2];
  logic [31:0] rd_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
           (sz == 3'd2 && a[1:0] != 2'b00) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int base;
    base = int'(a[9:2]) * 4;
    return {rmem[d][base+3], rmem[d][base+2], rmem[d][base+1], rmem[d][base]};
  endfunction

  task automatic model_write(input int d, input txn_t t);
    int nb;
    int b;
    nb = (t.size == 3'd0) ? 1 : (t.size == 3'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      b = int'(t.addr[9:0]) + i;
      rmem[d][b] = t.wdata[8*(b%4) +: 8];
    end
  endtask

  // Walk the pending data phase cycle by cycle. Entered at posedge+1 and
  // returns at posedge+1 just after the edge that closes the data phase.
  task automatic run_data_phase(input int d);
    txn_t        t;
    int          n;
    bit          last;
    logic [31:0] exp_rd;
    t = pend[d];
    n = t.err ? 2 : (t.xfer ? ws_of[d] + 1 : 1);
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      @(negedge clk);
      exp_rd = (last && t.xfer && !t.err && !t.write) ? model_word(d, t.addr) : 32'd0;
      check("hreadyout", {31'd0, hreadyout[d]}, {31'd0, last});
      check("hresp", {30'd0, hresp[d]}, t.err ? 32'd1 : 32'd0);
      check("hrdata", hrdata[d], exp_rd);
      if (last && t.xfer && !t.err && !t.write) begin
        last_rd[d] = hrdata[d];
        rd_log.push_back(hrdata[d]);
      end
      @(posedge clk);
      #1;
    end
    if (t.xfer && !t.err && t.write) model_write(d, t);
  endtask

  task automatic issue(input int d, input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [2:0] bu);
    hsel[d]   = sel;
    htrans[d] = tr;
    hwrite[d] = wr;
    haddr[d]  = a;
    hsize[d]  = sz;
    hburst[d] = bu;
    hwdata[d] = pend[d].write ? pend[d].wdata : $urandom;
    run_data_phase(d);
    pend[d].xfer  = sel && tr[1];
    pend[d].err   = sel && tr[1] && is_err(a, sz);
    pend[d].write = wr;
    pend[d].addr  = a;
    pend[d].size  = sz;
    pend[d].wdata = wd;
  endtask

  task automatic idle(input int d);
    issue(d, 1'b0, T_IDLE, 1'b0, 32'd0, 3'd0, 32'd0, 3'd0);
  endtask

  task automatic rand_txn(input int d);
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;
    r  = $urandom_range(0, 9);
    tr = (r < 1) ? T_IDLE : (r < 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
    sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    a  = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) != 0) begin
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
    end
    if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(10, 31));
    issue(d, $urandom_range(0, 19) != 0, tr, 1'($urandom_range(0, 1)), a, sz,
          $urandom, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    logic [31:0] old;
    ws_of[0] = 2;
    ws_of[1] = 0;
    for (int d = 0; d < 2; d++) begin
      pend[d]    = '{xfer: 1'b0, err: 1'b0, write: 1'b0, addr: 32'd0, size: 3'd0, wdata: 32'd0};
      haddr[d]   = 32'd0;
      htrans[d]  = T_IDLE;
      hsize[d]   = 3'd0;
      hburst[d]  = 3'd0;
      hwdata[d]  = 32'd0;
      last_rd[d] = 32'd0;
    end
    hsel      = 2'b00;
    hwrite    = 2'b00;
    hready_en = 2'b11;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_hreadyout", {31'd0, hreadyout[d]}, 32'd1);
      check("rst_hresp", {30'd0, hresp[d]}, 32'd0);
      check("rst_hrdata", hrdata[d], 32'd0);
    end
    @(posedge clk);
    #1;

    // Fill both arrays so every later read has a defined expectation
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++) issue(d, 1'b1, T_NSEQ, 1'b1, 32'(w * 4), 3'd2, $urandom, 3'd0);
      idle(d);
    end

    // Word write then read with two wait states
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b0, 32'h010, 3'd2, 32'd0, 3'd0);
    idle(0);
    check("word_rd", last_rd[0], 32'hDEADBEEF);

    // Byte write to lane 3
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h013, 3'd0, 32'h11223344, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b0, 32'h010, 3'd2, 32'd0, 3'd0);
    idle(0);
    check("byte_rd", last_rd[0], 32'h11ADBEEF);

    // Illegal transfers must not touch memory
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h002, 3'd2, 32'hFFFFFFFF, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h011, 3'd1, 32'hFFFFFFFF, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h010, 3'd3, 32'hFFFFFFFF, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 3'd0);
    issue(0, 1'b1, T_NSEQ, 1'b0, 32'h010, 3'd2, 32'd0, 3'd0);
    idle(0);
    check("err_nowrite", last_rd[0], 32'hDEADBEEF & 32'h00FFFFFF | 32'h11000000);

    // Selected NONSEQ while the bus is held by another slave: not accepted
    idle(0);
    hready_en[0] = 1'b0;
    hsel[0]      = 1'b1;
    htrans[0]    = T_NSEQ;
    hwrite[0]    = 1'b0;
    haddr[0]     = 32'h010;
    hsize[0]     = 3'd2;
    @(posedge clk);
    #1;
    hready_en[0] = 1'b1;
    hsel[0]      = 1'b0;
    htrans[0]    = T_IDLE;
    @(negedge clk);
    check("noaccept_rdy", {31'd0, hreadyout[0]}, 32'd1);
    check("noaccept_rd", hrdata[0], 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 120; i++) rand_txn(0);
    idle(0);

    // Zero-wait pipelined writes then INCR4 read with a BUSY after beat 2
    for (int i = 0; i < 4; i++) issue(1, 1'b1, (i == 0) ? T_NSEQ : T_SEQ, 1'b1,
                                      32'h020 + 32'(4 * i), 3'd2, 32'(i + 1), 3'd1);
    rd_log.delete();
    issue(1, 1'b1, T_NSEQ, 1'b0, 32'h020, 3'd2, 32'd0, 3'd3);
    issue(1, 1'b1, T_SEQ,  1'b0, 32'h024, 3'd2, 32'd0, 3'd3);
    issue(1, 1'b1, T_BUSY, 1'b0, 32'h028, 3'd2, 32'd0, 3'd3);
    issue(1, 1'b1, T_SEQ,  1'b0, 32'h028, 3'd2, 32'd0, 3'd3);
    issue(1, 1'b1, T_SEQ,  1'b0, 32'h02C, 3'd2, 32'd0, 3'd3);
    idle(1);
    check("incr4_count", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("incr4_data", (i < rd_log.size()) ? rd_log[i] : 32'hX, 32'(i + 1));

    // Read immediately after a write to the same word
    issue(1, 1'b1, T_NSEQ, 1'b1, 32'h030, 3'd2, 32'hCAFEF00D, 3'd0);
    issue(1, 1'b1, T_NSEQ, 1'b0, 32'h030, 3'd2, 32'd0, 3'd0);
    idle(1);
    check("raw_same_addr", last_rd[1], 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) rand_txn(1);
    idle(1);
    idle(0);

    // Reset while a write sits in its wait states
    old = model_word(0, 32'h040);
    issue(0, 1'b1, T_NSEQ, 1'b1, 32'h040, 3'd2, ~old, 3'd0);
    hsel[0]   = 1'b0;
    htrans[0] = T_IDLE;
    hwdata[0] = ~old;
    @(negedge clk);
    check("wait_before_rst", {31'd0, hreadyout[0]}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_hreadyout", {31'd0, hreadyout[0]}, 32'd1);
    check("arst_hresp", {30'd0, hresp[0]}, 32'd0);
    check("arst_hrdata", hrdata[0], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    pend[0] = '{xfer: 1'b0, err: 1'b0, write: 1'b0, addr: 32'd0, size: 3'd0, wdata: 32'd0};
    issue(0, 1'b1, T_NSEQ, 1'b0, 32'h040, 3'd2, 32'd0, 3'd0);
    idle(0);
    check("rst_nowrite", last_rd[0], old);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
